// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style main controller: Moore FSM sequencing fetch, decode,
// execute and writeback, plus the R-type funct decoder and PC enable logic.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state, nextstate;
  logic       pcwrite, branch, branchne;
  logic       memwrite_s, irwrite_s, regwrite_s;
  logic [2:0] funct_alu;

  // State register; reset returns to FETCH from any state.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextstate;
  end

  // R-type funct field to ALU operation; unknown functs default to add.
  always_comb begin
    funct_alu = 3'b010;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_alu = 3'b010;
    endcase
  end

  // Next-state and Moore outputs; anything not driven by a state stays 0.
  always_comb begin
    nextstate  = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = '0;
    pcsrc      = '0;
    alucontrol = '0;
    case (state)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        irwrite_s  = 1'b1;
        pcwrite    = 1'b1;
        nextstate  = DECODE;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        case (op)
          OP_LW, OP_SW:   nextstate = MEMADR;
          OP_RTYPE:       nextstate = EXECUTE;
          OP_BEQ, OP_BNE: nextstate = BRANCH;
          OP_ADDI:        nextstate = ADDIEXEC;
          OP_J:           nextstate = JUMP;
          default:        nextstate = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        nextstate  = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord      = 1'b1;
        nextstate = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        nextstate  = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = (op == OP_BEQ);
        branchne   = (op == OP_BNE);
      end
      ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        nextstate  = ADDIWB;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: nextstate = FETCH;
    endcase
  end

  // Write enables are gated by reset so nothing commits while it is held.
  assign pcen     = ~reset & (pcwrite | (branch & zero) | (branchne & ~zero));
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle-by-cycle
// expectations built from the opcode/latency tables, directed and random.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  // Packed view: {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol}
  function automatic logic [14:0] obs();
    return {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
            alusrcb, pcsrc, alucontrol};
  endfunction

  function automatic logic [2:0] funct_op(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000101, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs for cycle 'cyc' of an instruction (cycle 0 = FETCH).
  function automatic logic [14:0] exp_vec(input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input int cyc);
    logic pc = 0, mw = 0, irw = 0, rw = 0, asa = 0, io = 0, m2r = 0, rd = 0;
    logic [1:0] asb = 0, ps = 0;
    logic [2:0] alu = 0;
    if (cyc == 0) begin
      asb = 2'b01; alu = 3'b010; irw = 1; pc = 1;
    end else if (cyc == 1) begin
      asb = 2'b11; alu = 3'b010;
    end else begin
      case (o)
        6'b100011: begin
          if (cyc == 2) begin asa = 1; asb = 2'b10; alu = 3'b010; end
          if (cyc == 3) io = 1;
          if (cyc == 4) begin m2r = 1; rw = 1; end
        end
        6'b101011: begin
          if (cyc == 2) begin asa = 1; asb = 2'b10; alu = 3'b010; end
          if (cyc == 3) begin io = 1; mw = 1; end
        end
        6'b000000: begin
          if (cyc == 2) begin asa = 1; alu = funct_op(f); end
          if (cyc == 3) begin rd = 1; rw = 1; end
        end
        6'b001000: begin
          if (cyc == 2) begin asa = 1; asb = 2'b10; alu = 3'b010; end
          if (cyc == 3) rw = 1;
        end
        6'b000100: begin asa = 1; alu = 3'b110; ps = 2'b01; pc = z;  end
        6'b000101: begin asa = 1; alu = 3'b110; ps = 2'b01; pc = ~z; end
        6'b000010: begin ps = 2'b10; pc = 1; end
        default: ;
      endcase
    end
    return {pc, mw, irw, rw, asa, io, m2r, rd, asb, ps, alu};
  endfunction

  // Runs one instruction from FETCH (called just after a rising edge) back to FETCH.
  // zmode: 0/1 forces zero, 2 randomizes it each cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input string name);
    int rw_n = 0, mw_n = 0;
    int exp_rw, exp_mw;
    logic [14:0] e;
    op = o; funct = f;
    for (int c = 0; c < latency(o); c++) begin
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      e = exp_vec(o, f, zero, c);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s op=%b funct=%b cyc=%0d zero=%b got=%h exp=%h",
                 name, o, f, c, zero, obs(), e);
      end
      rw_n += int'(regwrite);
      mw_n += int'(memwrite);
      @(posedge clk); #1;
    end
    exp_rw = (o == 6'b100011 || o == 6'b000000 || o == 6'b001000) ? 1 : 0;
    exp_mw = (o == 6'b101011) ? 1 : 0;
    checks++;
    if (rw_n != exp_rw || mw_n != exp_mw) begin
      errors++;
      $display("FAIL %s_wcount op=%b regwrite_cycles=%0d exp=%0d memwrite_cycles=%0d exp=%0d",
               name, o, rw_n, exp_rw, mw_n, exp_mw);
    end
  endtask

  task automatic check_reset_held(input string name);
    #1;
    checks++;
    if ({pcen, irwrite, regwrite, memwrite} !== 4'b0000) begin
      errors++;
      $display("FAIL %s enables got=%b exp=0000", name, {pcen, irwrite, regwrite, memwrite});
    end
  endtask

  task automatic test_reset();
    reset = 1; op = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_reset_held("reset_hold");
      checks++;
      if (alusrcb !== 2'b01 || alucontrol !== 3'b010) begin
        errors++;
        $display("FAIL reset_state alusrcb=%b alucontrol=%b exp=01/010", alusrcb, alucontrol);
      end
    end
    reset = 0;
    #1;
    checks++;
    if (pcen !== 1'b1 || irwrite !== 1'b1) begin
      errors++;
      $display("FAIL reset_release pcen=%b irwrite=%b exp=1/1", pcen, irwrite);
    end
  endtask

  // Asserts reset at cycle stop_cyc of an lw and checks nothing is committed.
  task automatic test_reset_mid(input int stop_cyc);
    logic [14:0] e;
    op = 6'b100011; funct = '0; zero = 0;
    for (int c = 0; c < stop_cyc; c++) begin
      #1;
      e = exp_vec(op, funct, zero, c);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", c, obs(), e);
      end
      @(posedge clk); #1;
    end
    reset = 1;
    check_reset_held("reset_mid_in_state");
    @(posedge clk); #1;
    check_reset_held("reset_mid_after_edge");
    checks++;
    if (alusrcb !== 2'b01 || iord !== 1'b0 || memtoreg !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fetch alusrcb=%b iord=%b memtoreg=%b exp=01/0/0",
               alusrcb, iord, memtoreg);
    end
    reset = 0;
    run_instr(6'b000010, '0, 2, "post_reset_j");
  endtask

  task automatic test_lw();      run_instr(6'b100011, '0, 2, "lw"); endtask
  task automatic test_sw();      run_instr(6'b101011, '0, 2, "sw"); endtask
  task automatic test_rtype();
    run_instr(6'b000000, 6'b101010, 2, "rtype_slt");
    run_instr(6'b000000, 6'b100010, 2, "rtype_sub");
    run_instr(6'b000000, 6'b111111, 2, "rtype_dflt");
  endtask
  task automatic test_branch();
    run_instr(6'b000100, '0, 1, "beq_taken");
    run_instr(6'b000100, '0, 0, "beq_not");
    run_instr(6'b000101, '0, 1, "bne_not");
    run_instr(6'b000101, '0, 0, "bne_taken");
  endtask
  task automatic test_jump_illegal();
    run_instr(6'b000010, '0, 2, "jump");
    run_instr(6'b111111, '0, 2, "illegal");
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b000101, 6'b001000, 6'b000010};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] o, f;
    for (int i = 0; i < 200; i++) begin
      o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      f = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(o, f, 2, "random");
    end
    #1;
    checks++;
    if (obs() !== exp_vec(6'b0, 6'b0, zero, 0)) begin
      errors++;
      $display("FAIL final_fetch got=%h exp=%h", obs(), exp_vec(6'b0, 6'b0, zero, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_branch();
    test_jump_illegal();
    test_reset_mid(3);
    test_reset_mid(4);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
